// File: rtl/timer_pkg.sv
// Shared types and constants for the stopwatch controller (timer_ctrl).
package timer_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } tc_state_t;

  // Command codes ordered by priority: a larger code wins when commands collide.
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LAP   = 3'd1,
    CMD_START = 3'd2,
    CMD_STOP  = 3'd3,
    CMD_CLEAR = 3'd4
  } tc_cmd_t;

  function automatic tc_cmd_t tc_cmd_pick(input logic clear, input logic stop,
                                          input logic start, input logic lap);
    tc_cmd_t cmd;
    cmd = CMD_NONE;
    if (clear)      cmd = CMD_CLEAR;
    else if (stop)  cmd = CMD_STOP;
    else if (start) cmd = CMD_START;
    else if (lap)   cmd = CMD_LAP;
    return cmd;
  endfunction

endpackage

// File: rtl/timer_ctrl_prescaler.sv
// Count-tick prescaler for timer_ctrl: counts 0..DIV-1 while running, flags the wrap.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart)
      cnt_d = '0;
    else if (run)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = run & (cnt_q == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch controller: RUN/PAUSE/DONE FSM, prescaled count strobe, limit stop, lap capture.
// Lap capture is built only when TIMER_CTRL_LAP_EN is defined; otherwise lap outputs are tied off.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned        DIV   = 4,
  parameter logic [TIMER_W-1:0] LIMIT = 16'd1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               lap,
  input  logic               clear,
  input  logic               t_valid,
  input  logic [TIMER_W-1:0] t_out,
  output logic               t_en,
  output logic               t_clr,
  output logic               busy,
  output logic               done,
  output logic [TIMER_W-1:0] lap_val,
  output logic               lap_stb
);

  tc_state_t state_q, state_d;
  logic      t_clr_q, t_clr_d;
  tc_cmd_t   cmd;
  logic      at_limit;
  logic      tick;
  logic      restart;

  assign cmd      = tc_cmd_pick(clear, stop, start, lap);
  assign at_limit = t_valid & (t_out == LIMIT);

  always_comb begin
    state_d = state_q;
    t_clr_d = 1'b0;
    case (cmd)
      CMD_CLEAR: begin
        state_d = ST_IDLE;
        t_clr_d = 1'b1;
      end
      CMD_STOP: begin
        if (state_q == ST_RUN) state_d = ST_PAUSE;
      end
      CMD_START: begin
        if (state_q != ST_RUN) begin
          state_d = ST_RUN;
          t_clr_d = (state_q != ST_PAUSE);
        end
      end
      default: ;
    endcase
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && at_limit)
      state_d = ST_DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      t_clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_clr_q <= t_clr_d;
    end
  end

  assign restart = (state_d == ST_RUN) && (state_q != ST_RUN);

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == ST_RUN),
    .restart (restart),
    .tick    (tick)
  );

  // The timer clears while t_clr is high, so an increment in that cycle would be lost.
  assign t_en  = (state_q == ST_RUN) & tick & ~t_clr_q & (t_out != LIMIT);
  assign t_clr = t_clr_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

`ifdef TIMER_CTRL_LAP_EN
  logic [TIMER_W-1:0] lap_val_q, lap_val_d;
  logic               lap_stb_q, lap_stb_d;

  always_comb begin
    lap_val_d = lap_val_q;
    lap_stb_d = 1'b0;
    if ((cmd == CMD_LAP) && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
      lap_val_d = t_valid ? t_out : '0;
      lap_stb_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_val_q <= '0;
      lap_stb_q <= 1'b0;
    end else begin
      lap_val_q <= lap_val_d;
      lap_stb_q <= lap_stb_d;
    end
  end

  assign lap_val = lap_val_q;
  assign lap_stb = lap_stb_q;
`else
  assign lap_val = '0;
  assign lap_stb = 1'b0;
`endif

endmodule
